instr_encoder: RTL
==================

Name: instr_encoder

Overview:
- Writer-side counterpart of the control decoder: converts field-level instruction descriptions (class, command, registers, immediate) into 32-bit ARM words in the subset the decoder accepts.
- Streams the encoded words into instruction memory through a write port at consecutive word addresses.
- Used by the self-test loader and bench program generation.
- Has a valid/ready input handshake, a registered output stage, an address/word counter and a fill FSM.

Parameters:
- DEPTH, 64, maximum words written before FULL (1..65535).
- BASE_ADDR, 32'h0, byte address loaded into the address counter on reset.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  descriptor valid
- in_ready  output  1  encoder can accept a descriptor this cycle
- in_class  input  2  00 data-processing, 01 memory, 10 branch, 11 illegal
- in_cmd  input  4  DP command: ADD 0100, SUB 0010, AND 0000, ORR 1100, TST 1000, CMP 1010, CMN 1011
- in_s  input  1  set-flags request (DP only)
- in_cond  input  4  condition field
- in_rn  input  4  first source register
- in_rd  input  4  destination register
- in_rm  input  4  register operand or offset
- in_imm_en  input  1  use immediate instead of Rm (DP/MEM)
- in_imm  input  24  immediate: DP uses [7:0], MEM uses [11:0], branch uses [23:0]
- in_load  input  1  MEM: 1 = LDR, 0 = STR
- clear  input  1  synchronous: reset counters and error, return to RUN
- imem_we  output  1  instruction-memory write strobe
- imem_addr  output  32  byte address of the write
- imem_wdata  output  32  encoded instruction
- words_written  output  16  count of words written since reset/clear
- full  output  1  DEPTH words written
- err_illegal  output  1  sticky: an illegal descriptor was rejected

Behaviour:
- Reset (reset_n low, asynchronous):
  - imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, words_written=0, full=0, err_illegal=0.
  - FSM=RUN, in_ready=0 while in reset.
- FSM states:
  - RUN: in_ready=1. Accept occurs when in_valid & in_ready.
  - FULL: in_ready=0; descriptors ignored; only clear or reset exits.
- Latency:
  - Descriptor accepted in cycle N → imem_we=1 in cycle N+1 with imem_addr/imem_wdata registered.
  - imem_we is a single-cycle pulse per accepted legal descriptor.
  - Back-to-back accepts give one write per cycle.
- Address: imem_addr is the address of the current write; it advances by 4 after each write. The counter increments modulo 2^32 (wraps silently).
- words_written increments in the same cycle imem_we is asserted.
- FULL entry: when a write makes words_written == DEPTH, full=1, FSM=FULL and in_ready drops the next cycle.
- Encoding, all classes: bits[31:28] = in_cond.
- DP encoding:
  - [27:26] = 00; [25] = in_imm_en; [24:21] = in_cmd; [20] = in_s.
  - [19:16] = Rn; [15:12] = Rd.
  - [11:0] = {4'b0, imm[7:0]} if immediate, else {8'b0, Rm}.
  - TST/CMP/CMN: S forced to 1 and Rd forced to 0.
- MEM encoding:
  - [27:26] = 01; [25] = ~in_imm_en; [24:21] = 4'b1100 (P=1, U=1, B=0, W=0); [20] = in_load.
  - [19:16] = Rn; [15:12] = Rd.
  - [11:0] = imm[11:0] if immediate, else {8'b0, Rm}.
- Branch encoding: [27:24] = 1010; [23:0] = imm[23:0].
- Illegal descriptor (class 11, or DP with an unlisted cmd):
  - Accepted (handshake completes) but not written: no imem_we, counters unchanged.
  - err_illegal set and held until clear or reset.
- clear:
  - Takes priority over an accept in the same cycle; that descriptor is dropped.
  - Next cycle: words_written=0, imem_addr=BASE_ADDR, full=0, err_illegal=0, FSM=RUN, imem_we=0.
- Simultaneous: the accept that reaches DEPTH is written normally; in the same cycle full is asserted and in_ready deasserts.
- Reset mid-stream: any pending write is discarded.

Decomposition:
- Shared package instr_pkg:
  - class codes (CLS_DP, CLS_MEM, CLS_BR).
  - DP command constants (CMD_ADD, CMD_SUB, CMD_AND, CMD_ORR, CMD_TST, CMD_CMP, CMD_CMN).
  - bit-field position constants.
  - These are shared with the decoder and the bench.
- One combinational sub-module instr_pack: descriptor → 32-bit word plus legal flag.
- The top holds the FSM, counters and output register.

Test Plan:
1. After reset, ADD cond=1110, S=0, Rn=1, Rd=2, imm_en=1, imm=5 → next cycle imem_we=1, addr=0x0, wdata=0xE2812005, words_written=1.
2. Back-to-back:
   - STR Rn=0, Rd=3, imm=8 gives wdata=0xE5803008 at addr 0x4.
   - LDR with register offset Rm=4 gives 0xE7903004 at addr 0x8.
   - Branch imm=0xFFFFFE gives 0xEAFFFFFE at addr 0xC.
3. CMP with S=0, Rd=7, Rn=2, imm=3 → wdata=0xE3520003 (S forced to 1, Rd forced to 0).
4. class=11 accepted → no imem_we, err_illegal=1, address unchanged. The following legal word is written at the unchanged address.
5. DEPTH=4: four writes → full=1, in_ready=0; a fifth in_valid produces no write. clear → addr back to BASE_ADDR, full=0, count=0.
6. reset_n pulsed low mid-stream with in_valid held → imem_we drops immediately, outputs at reset values; first post-reset write goes to BASE_ADDR.

Source files
------------

// File: rtl/instr_pkg.sv
// Shared instruction-field definitions used by the encoder, the decoder and the bench.
package instr_pkg;

  typedef enum logic [1:0] {
    CLS_DP  = 2'b00,
    CLS_MEM = 2'b01,
    CLS_BR  = 2'b10,
    CLS_ILL = 2'b11
  } instr_class_e;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_CMN = 4'b1011;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // Bit-field positions of the 32-bit instruction word
  localparam int COND_LSB = 28;
  localparam int OP_LSB   = 26;
  localparam int I_BIT    = 25;
  localparam int OPC_LSB  = 21;
  localparam int S_BIT    = 20;
  localparam int RN_LSB   = 16;
  localparam int RD_LSB   = 12;

  localparam logic [3:0] MEM_PUBW = 4'b1100;  // pre-index, up, word, no writeback
  localparam logic [3:0] BR_OP    = 4'b1010;

  function automatic logic dp_cmd_legal(input logic [3:0] cmd);
    return (cmd == CMD_AND) || (cmd == CMD_SUB) || (cmd == CMD_ADD) ||
           (cmd == CMD_ORR) || (cmd == CMD_TST) || (cmd == CMD_CMP) ||
           (cmd == CMD_CMN);
  endfunction

  // Compare-only commands have no destination and always set flags
  function automatic logic dp_is_compare(input logic [3:0] cmd);
    return (cmd == CMD_TST) || (cmd == CMD_CMP) || (cmd == CMD_CMN);
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Descriptor handshake between a program generator (master) and the encoder (slave).
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_class;
  logic [3:0]  in_cmd;
  logic        in_s;
  logic [3:0]  in_cond;
  logic [3:0]  in_rn;
  logic [3:0]  in_rd;
  logic [3:0]  in_rm;
  logic        in_imm_en;
  logic [23:0] in_imm;
  logic        in_load;

  modport master (
    output in_valid, in_class, in_cmd, in_s, in_cond, in_rn, in_rd, in_rm,
           in_imm_en, in_imm, in_load,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_class, in_cmd, in_s, in_cond, in_rn, in_rd, in_rm,
           in_imm_en, in_imm, in_load,
    output in_ready
  );
endinterface

// File: rtl/instr_pack.sv
// Combinational packer: field-level descriptor to 32-bit instruction word plus legal flag.
module instr_pack
  import instr_pkg::*;
(
  input  logic [1:0]  cls,
  input  logic [3:0]  cmd,
  input  logic        s,
  input  logic [3:0]  cond,
  input  logic [3:0]  rn,
  input  logic [3:0]  rd,
  input  logic [3:0]  rm,
  input  logic        imm_en,
  input  logic [23:0] imm,
  input  logic        load,
  output logic [31:0] word,
  output logic        legal
);

  // Field assembly per instruction class
  always_comb begin
    word  = '0;
    legal = 1'b0;
    word[COND_LSB +: 4] = cond;
    case (instr_class_e'(cls))
      CLS_DP: begin
        legal              = dp_cmd_legal(cmd);
        word[OP_LSB +: 2]  = 2'b00;
        word[I_BIT]        = imm_en;
        word[OPC_LSB +: 4] = cmd;
        word[S_BIT]        = s | dp_is_compare(cmd);
        word[RN_LSB +: 4]  = rn;
        word[RD_LSB +: 4]  = dp_is_compare(cmd) ? 4'h0 : rd;
        word[11:0]         = imm_en ? {4'h0, imm[7:0]} : {8'h00, rm};
      end
      CLS_MEM: begin
        legal              = 1'b1;
        word[OP_LSB +: 2]  = 2'b01;
        word[I_BIT]        = ~imm_en;
        word[OPC_LSB +: 4] = MEM_PUBW;
        word[S_BIT]        = load;
        word[RN_LSB +: 4]  = rn;
        word[RD_LSB +: 4]  = rd;
        word[11:0]         = imm_en ? imm[11:0] : {8'h00, rm};
      end
      CLS_BR: begin
        legal        = 1'b1;
        word[27:24]  = BR_OP;
        word[23:0]   = imm;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts descriptors, packs them and streams words into
// instruction memory at consecutive addresses until DEPTH words are written.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_RUN  | accepting descriptors, one write per accepted legal one
//   ST_FULL | DEPTH words written, descriptors ignored until clear/reset
module instr_encoder
  import instr_pkg::*;
#(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic            clk,
  input  logic            reset_n,
  instr_encoder_if.slave  desc,
  input  logic            clear,
  output logic            imem_we,
  output logic [31:0]     imem_addr,
  output logic [31:0]     imem_wdata,
  output logic [15:0]     words_written,
  output logic            full,
  output logic            err_illegal
);

  typedef enum logic {ST_RUN, ST_FULL} state_e;

  localparam logic [15:0] DEPTH_W = 16'(DEPTH);

  state_e      state;
  logic [31:0] next_addr;
  logic [31:0] pack_word;
  logic        pack_legal;
  logic        accept;

  instr_pack u_pack (
    .cls    (desc.in_class),
    .cmd    (desc.in_cmd),
    .s      (desc.in_s),
    .cond   (desc.in_cond),
    .rn     (desc.in_rn),
    .rd     (desc.in_rd),
    .rm     (desc.in_rm),
    .imm_en (desc.in_imm_en),
    .imm    (desc.in_imm),
    .load   (desc.in_load),
    .word   (pack_word),
    .legal  (pack_legal)
  );

  assign accept = desc.in_valid & desc.in_ready & (state == ST_RUN);

  // Fill FSM with registered write port, counters and status
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_RUN;
      desc.in_ready <= 1'b0;
      imem_we       <= 1'b0;
      imem_addr     <= BASE_ADDR;
      imem_wdata    <= '0;
      next_addr     <= BASE_ADDR;
      words_written <= '0;
      full          <= 1'b0;
      err_illegal   <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      if (clear) begin
        state         <= ST_RUN;
        desc.in_ready <= 1'b1;
        imem_addr     <= BASE_ADDR;
        next_addr     <= BASE_ADDR;
        words_written <= '0;
        full          <= 1'b0;
        err_illegal   <= 1'b0;
      end else begin
        case (state)
          ST_RUN: begin
            desc.in_ready <= 1'b1;
            if (accept) begin
              if (pack_legal) begin
                imem_we       <= 1'b1;
                imem_addr     <= next_addr;
                imem_wdata    <= pack_word;
                next_addr     <= next_addr + 32'd4;
                words_written <= words_written + 16'd1;
                if (words_written + 16'd1 == DEPTH_W) begin
                  full          <= 1'b1;
                  state         <= ST_FULL;
                  desc.in_ready <= 1'b0;
                end
              end else begin
                err_illegal <= 1'b1;
              end
            end
          end
          ST_FULL: begin
            desc.in_ready <= 1'b0;
          end
          default: begin
            state         <= ST_RUN;
            desc.in_ready <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
